// File: rtl/binary_mul_4bit.sv
// Two-stage pipelined 4x4 array multiplier (AND partial products + full-adder rows).
// Define BINARY_MUL_SIGNED_EN to add the tc port for Baugh-Wooley two's-complement products.
module binary_mul_4bit (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
`ifdef BINARY_MUL_SIGNED_EN
    input  logic       tc,
`endif
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic       out_valid,
    output logic [7:0] M
);

    logic       tc_s;
    logic [3:0] pp0, pp1, pp2, pp3;
    logic [7:0] acc2, prod;

    logic [5:0] sum1_d, sum1_q;
    logic [3:0] a_d, a_q;
    logic [1:0] bh_d, bh_q;
    logic       tc_d, tc_q;
    logic       v1_d, v1_q;
    logic [7:0] m_d, m_q;
    logic       out_valid_d, out_valid_q;

`ifdef BINARY_MUL_SIGNED_EN
    assign tc_s = tc;
`else
    assign tc_s = 1'b0;
`endif

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

    function automatic logic [5:0] fa_row5(input logic [4:0] x, input logic [4:0] y);
        logic       c;
        logic [1:0] r;
        logic [5:0] s;
        c = 1'b0;
        s = '0;
        for (int unsigned k = 0; k < 5; k++) begin
            r    = full_add(x[k], y[k], c);
            s[k] = r[0];
            c    = r[1];
        end
        s[5] = c;
        return s;
    endfunction

    function automatic logic [7:0] ripple_add8(input logic [7:0] x, input logic [7:0] y);
        logic       c;
        logic [1:0] r;
        logic [7:0] s;
        c = 1'b0;
        s = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            r    = full_add(x[k], y[k], c);
            s[k] = r[0];
            c    = r[1];
        end
        return s;
    endfunction

    // Baugh-Wooley: invert terms where exactly one operand bit is a sign bit,
    // and add constants 2^4 (stage 1, bit 4 of row-0 operand) and 2^7 (stage 2).
    always_comb begin
        pp0    = A & {4{B[0]}};
        pp1    = A & {4{B[1]}};
        pp0[3] = pp0[3] ^ tc_s;
        pp1[3] = pp1[3] ^ tc_s;

        v1_d   = in_valid;
        sum1_d = sum1_q;
        a_d    = a_q;
        bh_d   = bh_q;
        tc_d   = tc_q;
        if (in_valid) begin
            sum1_d = fa_row5({tc_s, pp0}, {pp1, 1'b0});
            a_d    = A;
            bh_d   = B[3:2];
            tc_d   = tc_s;
        end
    end

    always_comb begin
        pp2      = a_q & {4{bh_q[0]}};
        pp3      = a_q & {4{bh_q[1]}};
        pp2[3]   = pp2[3] ^ tc_q;
        pp3[2:0] = pp3[2:0] ^ {3{tc_q}};

        acc2 = ripple_add8({2'b00, sum1_q}, {2'b00, pp2, 2'b00});
        prod = ripple_add8(acc2, {tc_q, pp3, 3'b000});

        out_valid_d = v1_q;
        m_d         = v1_q ? prod : m_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum1_q      <= '0;
            a_q         <= '0;
            bh_q        <= '0;
            tc_q        <= 1'b0;
            v1_q        <= 1'b0;
            m_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            sum1_q      <= sum1_d;
            a_q         <= a_d;
            bh_q        <= bh_d;
            tc_q        <= tc_d;
            v1_q        <= v1_d;
            m_q         <= m_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign M         = m_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_binary_mul_4bit.sv
// Directed self-checking bench for binary_mul_4bit (signed vectors when BINARY_MUL_SIGNED_EN is defined).
module tb_binary_mul_4bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] A, B;
    logic       out_valid;
    logic [7:0] M;
`ifdef BINARY_MUL_SIGNED_EN
    logic       tc;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    binary_mul_4bit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
`ifdef BINARY_MUL_SIGNED_EN
        .tc        (tc),
`endif
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .M         (M)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b);
        in_valid = v;
        A        = a;
        B        = b;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 4'd0, 4'd0);
`ifdef BINARY_MUL_SIGNED_EN
        tc = 1'b0;
`endif
        #2;
        n_checks++;
        if (M !== 8'h00 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: M=%h out_valid=%b, required M=00 out_valid=0", M, out_valid);
        end
        cycle();
        cycle();
        #4 rst = 1'b0;
        cycle();
        drive(1'b1, 4'd3, 4'd3);
        cycle();
        drive(1'b1, 4'd4, 4'd4);
        cycle();
        n_checks++;
        if (out_valid !== 1'b1 || M !== 8'h09) begin
            n_fail++;
            $display("FAIL pre_reset_product: M=%h out_valid=%b, required M=09 out_valid=1", M, out_valid);
        end
        drive(1'b1, 4'd5, 4'd5);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (M !== 8'h00 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: M=%h out_valid=%b, required M=00 out_valid=0", M, out_valid);
        end
        cycle();
        cycle();
        n_checks++;
        if (M !== 8'h00 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL held_reset: M=%h out_valid=%b, required M=00 out_valid=0", M, out_valid);
        end
        drive(1'b1, 4'd2, 4'd3);
        #4 rst = 1'b0;
        cycle();
        drive(1'b0, 4'd0, 4'd0);
        n_checks++;
        if (M !== 8'h00 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL inflight_discard: M=%h out_valid=%b, required M=00 out_valid=0", M, out_valid);
        end
        cycle();
        n_checks++;
        if (M !== 8'h06 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL first_after_release: M=%h out_valid=%b, required M=06 out_valid=1", M, out_valid);
        end
        cycle();
        n_checks++;
        if (M !== 8'h06 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_release_hold: M=%h out_valid=%b, required M=06 out_valid=0", M, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] va [7] = '{4'd0, 4'd0, 4'd12, 4'd6, 4'd15, 4'd7, 4'd15};
        logic [3:0] vb [7] = '{4'd0, 4'd4, 4'd8,  4'd5, 4'd10, 4'd8, 4'd15};
        logic [7:0] vm [7] = '{8'h00, 8'h00, 8'h60, 8'h1E, 8'h96, 8'h38, 8'hE1};
        for (int i = 0; i < 8; i++) begin
            if (i < 7) drive(1'b1, va[i], vb[i]);
            else       drive(1'b0, 4'd0, 4'd0);
            cycle();
            n_checks++;
            if (i == 0) begin
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_idle_before: out_valid=%b, required 0", out_valid);
                end
            end else if (out_valid !== 1'b1 || M !== vm[i-1]) begin
                n_fail++;
                $display("FAIL b2b_vec%0d: M=%h out_valid=%b, required M=%h out_valid=1",
                         i - 1, M, out_valid, vm[i-1]);
            end
        end
    endtask

    task automatic test_gaps();
        logic       ev [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0] em [7] = '{8'hE1, 8'h1E, 8'h1E, 8'h1E, 8'h1E, 8'hE1, 8'hE1};
        for (int i = 0; i < 7; i++) begin
            if (i == 0)      drive(1'b1, 4'd6, 4'd5);
            else if (i == 4) drive(1'b1, 4'd15, 4'd15);
            else             drive(1'b0, 4'd0, 4'd0);
            cycle();
            n_checks++;
            if (out_valid !== ev[i] || M !== em[i]) begin
                n_fail++;
                $display("FAIL gap_cycle%0d: M=%h out_valid=%b, required M=%h out_valid=%b",
                         i, M, out_valid, em[i], ev[i]);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [7:0] q [$];
        logic [7:0] exp_m;
        logic [7:0] exp_last = 8'hE1;
        logic [3:0] a, b;
        int idx = 0, gap = 0, drain = 0, pulses = 0;
        while (idx < 256 || drain < 4) begin
            if (idx < 256 && gap == 0) begin
                a = idx[3:0];
                b = idx[7:4];
                drive(1'b1, a, b);
                q.push_back({4'd0, a} * {4'd0, b});
                idx++;
                gap = int'($urandom_range(0, 2));
            end else begin
                drive(1'b0, 4'd0, 4'd0);
                if (idx < 256) gap--;
                else           drain++;
            end
            cycle();
            n_checks++;
            if (out_valid === 1'b1) begin
                pulses++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL exh_spurious_pulse: M=%h out_valid=1, required no pulse", M);
                end else begin
                    exp_m = q.pop_front();
                    exp_last = exp_m;
                    if (M !== exp_m) begin
                        n_fail++;
                        $display("FAIL exh_product: M=%h, required %h", M, exp_m);
                    end
                end
            end else if (M !== exp_last) begin
                n_fail++;
                $display("FAIL exh_hold: M=%h out_valid=%b, required M=%h", M, out_valid, exp_last);
            end
        end
        n_checks++;
        if (pulses != 256 || q.size() != 0) begin
            n_fail++;
            $display("FAIL exh_pulse_count: pulses=%0d pending=%0d, required pulses=256 pending=0",
                     pulses, q.size());
        end
    endtask

`ifdef BINARY_MUL_SIGNED_EN
    task automatic test_signed();
        logic [3:0] va [6] = '{4'hF, 4'h8, 4'h8, 4'hF, 4'h8, 4'h8};
        logic [3:0] vb [6] = '{4'hF, 4'h7, 4'h8, 4'hF, 4'h7, 4'h8};
        logic       vt [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0] vm [6] = '{8'h01, 8'hC8, 8'h40, 8'hE1, 8'h38, 8'h40};
        for (int i = 0; i < 7; i++) begin
            if (i < 6) begin
                drive(1'b1, va[i], vb[i]);
                tc = vt[i];
            end else begin
                drive(1'b0, 4'd0, 4'd0);
                tc = 1'b0;
            end
            cycle();
            if (i > 0) begin
                n_checks++;
                if (out_valid !== 1'b1 || M !== vm[i-1]) begin
                    n_fail++;
                    $display("FAIL signed_vec%0d: M=%h out_valid=%b, required M=%h out_valid=1",
                             i - 1, M, out_valid, vm[i-1]);
                end
            end
        end
        cycle();
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_exhaustive();
`ifdef BINARY_MUL_SIGNED_EN
        test_signed();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/binary_mul_4bit.md
Name: binary_mul_4bit

Overview:
- Pipelined 4x4 unsigned binary multiplier producing an 8-bit product.
- Built as an explicit AND partial-product array with full-adder reduction rows.
- The array is split into two register stages for timing.
- Sits in datapaths needing small fixed-width products; accepts one operand pair per cycle with a valid flag.

Parameters:
- None. Operand width is fixed at 4 bits and product width at 8 bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  A/B are sampled this cycle
- A  input  4  multiplicand, unsigned
- B  input  4  multiplier, unsigned
- out_valid  output  1  M holds a new product this cycle (1-cycle pulse per accepted input)
- M  output  8  product A*B

Behaviour:
- Reset (async assert, sync release): M=8'h00, out_valid=0, all internal pipeline registers and valid bits cleared. While rst is high, no input is accepted.
- Partial products: pp[i][j] = A[j] & B[i].
- Stage 1, on a clk edge with in_valid=1:
  - register rows 0 and 1 summed by the first full-adder row (6-bit partial sum);
  - register A[3:0] and B[3:2];
  - set v1=1.
- Stage 2:
  - add rows 2 and 3 to the stage-1 sum through two ripple full-adder rows;
  - register the 8-bit result into M;
  - out_valid <= v1.
- Latency: exactly 2 clk edges from sampling (in_valid=1) to out_valid=1 with the matching M.
- Throughput: one product per cycle; back-to-back valid inputs give back-to-back out_valid pulses in order.
- in_valid=0:
  - stage-1 data registers hold and v1 <= 0;
  - the next cycle out_valid=0 and M holds its last value. M never changes without out_valid.
- Arithmetic: M = A*B unsigned, range 0..225. No overflow is possible in 8 bits, so there is no saturation and no flag.
- Reset mid-operation: in-flight products are discarded. No out_valid is produced for inputs sampled before reset.
- in_valid high in the first cycle after reset release is accepted normally.
- No handshake back-pressure: the block is always ready.

Optional Feature:
- Macro: BINARY_MUL_SIGNED_EN.
- With the macro defined:
  - extra input port tc (1 bit) is sampled with A/B and pipelined alongside them;
  - tc=1 treats A, B and M as two's complement, using Baugh-Wooley sign correction in the same array (M is the 8-bit signed product, range -56..64);
  - tc=0 gives the unsigned behaviour above;
  - latency and valid rules are unchanged.
- Without the macro: no tc port; the block is unsigned only.

Test Plan:
- Reset: assert rst mid-stream with two products in flight -> M=0x00 and out_valid=0 immediately. No out_valid for the in-flight products after release.
- Directed unsigned vectors, one per cycle back-to-back: (0,0), (0,4), (12,8), (6,5), (15,10), (7,8), (15,15).
  - Required M, each 2 cycles later with out_valid high every cycle: 0x00, 0x00, 0x60, 0x1E, 0x96, 0x38, 0xE1.
- Gaps: apply (6,5), drop in_valid for 3 cycles, then apply (15,15).
  - Required: out_valid pulses once for 0x1E; M holds 0x1E during the gap; then 0xE1 with a single pulse.
- Exhaustive: all 256 A/B pairs, random in_valid gaps -> every out_valid M equals A*B in input order; the count of out_valid pulses equals the count of accepted inputs.
- BINARY_MUL_SIGNED_EN with tc=1:
  - A=0xF, B=0xF -> M=0x01;
  - A=0x8, B=0x7 -> M=0xC8;
  - A=0x8, B=0x8 -> M=0x40;
  - tc=0 on the same operands -> 0xE1, 0x38, 0x40.
